// File: rtl/uart_rx2_if.sv
// Serial receive bus: the line into the receiver and the received byte/status coming back out.
// The master drives the line and consumes results; the slave is the receiver itself.
interface uart_rx2_if;
    logic       RX_DATA;
    logic [7:0] RX_BYTE;
    logic       RX_DV;
    logic       FRAME_ERR;
    logic       BUSY;

    modport master (output RX_DATA, input RX_BYTE, RX_DV, FRAME_ERR, BUSY);
    modport slave  (input RX_DATA, output RX_BYTE, RX_DV, FRAME_ERR, BUSY);
endinterface

// File: rtl/uart_rx2.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling from a per-bit cycle counter,
// one-cycle RX_DV / FRAME_ERR pulses, and break tolerance in CLEANUP.
//
// state   | meaning
// IDLE    | line idle, waiting for a synchronised low
// START   | half-bit wait, then confirm start bit is still low
// DATA    | sample 8 data bits at their midpoints, LSB first
// STOP    | sample stop bit, publish byte or flag framing error
// CLEANUP | wait for the line to return high before re-arming
module uart_rx2 #(
    parameter int UART_BAUD    = 9600,
    parameter int CLKS_PER_BIT = 12_000_000 / UART_BAUD
) (
    input  logic CLK,
    input  logic RST_N,
    uart_rx2_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;

    localparam logic [31:0] BIT_TC  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_TC = 32'((CLKS_PER_BIT / 2) - 1);

    logic        rx_meta;
    logic        rx_sync;
    logic [2:0]  state;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic [7:0]  rx_byte_q;
    logic        rx_dv_q;
    logic        frame_err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.RX_DATA;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) state <= START;
                end
                START: begin
                    if (cnt == HALF_TC) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt              <= '0;
                        shift_q[bit_idx] <= rx_sync;
                        bit_idx          <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_TC) begin
                        cnt   <= '0;
                        state <= CLEANUP;
                        if (rx_sync) begin
                            rx_byte_q <= shift_q;
                            rx_dv_q   <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CLEANUP: begin
                    // A held-low line (break) parks here instead of framing garbage.
                    cnt <= '0;
                    if (rx_sync) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    assign bus.RX_BYTE   = rx_byte_q;
    assign bus.RX_DV     = rx_dv_q;
    assign bus.FRAME_ERR = frame_err_q;
    assign bus.BUSY      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx2.sv
// Randomised bench for uart_rx2: frames are generated from bit times, the expected outcome of
// each frame is queued when it is sent, and a monitor pops and compares on every output pulse.
module tb_uart_rx2;
    localparam int CPB     = 16;
    localparam int LAT_MIN = 2 + 8 + 9 * CPB - 1;
    localparam int LAT_MAX = 2 + 8 + 9 * CPB + 3;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    uart_rx2_if bus ();

    uart_rx2 #(.CLKS_PER_BIT(CPB)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (bus.RX_DV || bus.FRAME_ERR) begin
                chk("pulse_exclusive", 32'(bus.RX_DV & bus.FRAME_ERR), 32'd0);
                chk("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 32'(bus.RX_DV) + 32'(bus.FRAME_ERR), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind_ferr", 32'(bus.FRAME_ERR), 32'(e.is_err));
                    chk("rx_byte", 32'(bus.RX_BYTE), 32'(e.data));
                    chk_range("latency", cyc - e.t0, LAT_MIN, LAT_MAX);
                end
            end
            if (bus.RX_BYTE != prev_byte && !bus.RX_DV)
                chk("rx_byte_hold", 32'(bus.RX_BYTE), 32'(prev_byte));
        end
        prev_pulse = bus.RX_DV | bus.FRAME_ERR;
        prev_byte  = bus.RX_BYTE;
    end

    task automatic idle(input int n);
        bus.RX_DATA = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge CLK);
            #1;
        end
    endtask

    // Bit boundaries are placed at floor(k * CPB * (100+err)/100) cycles so a frame can run fast or slow.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int err_pct, input int gap);
        logic [9:0] bits;
        int bl_num;
        int prev;
        int nb;
        bits   = {stop, d, 1'b0};
        bl_num = CPB * (100 + err_pct);
        prev   = 0;
        if (stop) begin
            last_good = d;
            q.push_back('{1'b0, d, cyc});
        end else begin
            q.push_back('{1'b1, last_good, cyc});
        end
        for (int i = 0; i < 10; i++) begin
            bus.RX_DATA = bits[i];
            nb = ((i + 1) * bl_num) / 100;
            repeat (nb - prev) @(posedge CLK);
            #1;
            prev = nb;
        end
        if (stop || gap > 0) idle(gap);
    endtask

    initial begin
        logic [7:0] byte_before;
        logic [9:0] abort_bits;
        int         busy_seen;
        int         busy_low;
        int         guard;

        bus.RX_DATA = 1'b1;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rx_byte", 32'(bus.RX_BYTE), 32'h00);
        chk("reset_rx_dv", 32'(bus.RX_DV), 32'd0);
        chk("reset_frame_err", 32'(bus.FRAME_ERR), 32'd0);
        chk("reset_busy", 32'(bus.BUSY), 32'd0);
        RST_N = 1'b1;
        idle(10);

        send_frame(8'hA5, 1'b1, 0, 20);
        chk("a5_held", 32'(bus.RX_BYTE), 32'hA5);

        // Short low glitch must be rejected at the start-bit midpoint check.
        byte_before = bus.RX_BYTE;
        busy_seen = 0;
        bus.RX_DATA = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        bus.RX_DATA = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            #1;
            if (bus.BUSY) busy_seen++;
        end
        chk("glitch_busy_seen", 32'(busy_seen > 0), 32'd1);
        chk("glitch_back_idle", 32'(bus.BUSY), 32'd0);
        chk("glitch_byte_kept", 32'(bus.RX_BYTE), 32'(byte_before));

        // Framing error followed by a long break.
        send_frame(8'h3C, 1'b0, 0, 0);
        bus.RX_DATA = 1'b0;
        busy_low = 0;
        for (int i = 0; i < 50 * CPB; i++) begin
            @(posedge CLK);
            #1;
            if (!bus.BUSY) busy_low++;
        end
        chk("break_busy_held", 32'(busy_low), 32'd0);
        chk("break_byte_kept", 32'(bus.RX_BYTE), 32'hA5);
        idle(10);
        chk("break_release_idle", 32'(bus.BUSY), 32'd0);

        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, 30);

        // Abort 0x55 in the middle of data bit 4 with a reset pulse.
        abort_bits = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.RX_DATA = abort_bits[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
        bus.RX_DATA = abort_bits[5];
        repeat (CPB / 2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        bus.RX_DATA = 1'b1;
        q.delete();
        last_good = 8'h00;
        repeat (5) @(posedge CLK);
        #1;
        chk("midreset_busy", 32'(bus.BUSY), 32'd0);
        chk("midreset_rx_byte", 32'(bus.RX_BYTE), 32'h00);
        RST_N = 1'b1;
        idle(40);
        chk("post_reset_rx_byte", 32'(bus.RX_BYTE), 32'h00);
        send_frame(8'h81, 1'b1, 0, 10);

        send_frame(8'hC3, 1'b1, 3, 10);
        send_frame(8'hC3, 1'b1, -3, 10);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit stop;
            int err;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            err  = int'($urandom_range(0, 6)) - 3;
            send_frame(d, stop, err, int'($urandom_range(4, 30)));
        end

        guard = 0;
        while (q.size() != 0 && guard < 500) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_idle", 32'(bus.BUSY), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
